// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: in-order {inst, pc} buffer between fetch and decode with single-cycle flush.
// Define FDQ_BYPASS_EN to let an empty queue forward in_* to out_* in the same cycle.
module fetch_decode_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [31:0]                in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_pc_plus4,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int            CW         = $clog2(DEPTH + 1);
    localparam int            AW         = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    logic stored_valid;
    logic bypass;
    logic bypass_take;
    logic push;
    logic pop;

    // in_ready depends only on registered occupancy, so a full queue never accepts even while popping.
    assign stored_valid = (count_q != '0);
    assign in_ready     = (count_q != FULL_COUNT);
    assign count        = count_q;

`ifdef FDQ_BYPASS_EN
    assign bypass      = ~stored_valid & in_valid & ~flush;
    assign bypass_take = bypass & out_ready;
`else
    assign bypass      = 1'b0;
    assign bypass_take = 1'b0;
`endif

    // A bypassed entry consumed in the same cycle is never written into storage.
    assign push = in_valid & in_ready & ~flush & ~bypass_take;
    assign pop  = stored_valid & out_ready & ~flush;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        out_valid = 1'b0;
        out_inst  = NOP_INST;
        out_pc    = '0;
        if (stored_valid) begin
            out_valid = 1'b1;
            out_inst  = mem[rd_ptr].inst;
            out_pc    = mem[rd_ptr].pc;
        end else if (bypass) begin
            out_valid = 1'b1;
            out_inst  = in_inst;
            out_pc    = in_pc;
        end
    end

    assign out_pc_plus4 = out_pc + 32'd4;

    // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            // Reset and flush leave identical state; reset wins only in the sense that it is unconditional.
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // NOTE: the entry RAM has no reset; stale contents are masked by the occupancy counter.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{inst: in_inst, pc: in_pc};
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= FULL_COUNT);

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Small instruction buffer between the fetch stage and the decode stage.
- Fetch pushes {instruction, PC} pairs; decode pops them in order through a valid/ready handshake.
- Absorbs decode stalls without gating the fetch PC every cycle.
- A branch redirect (flush) discards all buffered wrong-path instructions in one cycle.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- NOP_INST, 32'h0000_0013, value driven on out_inst whenever out_valid=0 (addi x0,x0,0).
- CW, $clog2(DEPTH+1), width of the count output (derived, not overridable).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- flush  input  1  branch redirect; discards all entries.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  queue can accept this cycle.
- in_inst  input  32  fetched instruction.
- in_pc  input  32  PC of in_inst.
- out_valid  output  1  head entry available to decode.
- out_ready  input  1  decode consumes head this cycle.
- out_inst  output  32  head instruction, or NOP_INST when empty.
- out_pc  output  32  head PC, or 0 when empty.
- out_pc_plus4  output  32  out_pc + 4, or 4 when empty.
- count  output  CW  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular buffer of DEPTH entries with wr_ptr/rd_ptr of log2(DEPTH) bits, wrapping naturally, plus a separate occupancy counter.
- Push: push = in_valid & in_ready & ~flush.
- in_ready = (count != DEPTH), purely from registered state. No push-through-pop when full: when full, in_ready=0 even if out_ready=1.
- Pop: pop = out_valid & out_ready & ~flush.
- out_valid = (count != 0).
- out_inst/out_pc are read combinationally from mem[rd_ptr]; out_pc_plus4 = out_pc + 32'd4, modulo 2^32 (PC 32'hFFFF_FFFC gives 0).
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1. No same-cycle bypass unless the optional feature is enabled.
- Simultaneous push and pop (count between 1 and DEPTH-1): count unchanged, both pointers advance.
- Push and pop with count==0: only the push takes effect, since out_valid=0.
- Flush has priority over push and pop:
  - Next cycle: count=0 and wr_ptr=rd_ptr=0.
  - A same-cycle push is dropped and a same-cycle pop is not counted.
  - Decode must ignore out_* during a flush cycle.
- Reset (sync, rst=1 at a rising edge) applies the same state as flush:
  - count=0, pointers 0, so out_valid=0, out_inst=NOP_INST, out_pc=0, out_pc_plus4=4, in_ready=1.
  - Reset mid-operation discards contents identically.
  - Reset has priority over flush.
- Entry RAM contents need no reset; outputs are masked while empty.
- Illegal conditions: in_valid with in_ready=0 holds data (fetch must not advance PC). Assertion: count never exceeds DEPTH.

Optional Feature:
- Macro FDQ_BYPASS_EN.
- When defined:
  - If count==0 and in_valid=1, out_valid=1 in the same cycle, with out_inst/out_pc taken from in_inst/in_pc.
  - If out_ready=1 that cycle, the entry is consumed and never written; count stays 0.
  - If out_ready=0, the entry is written normally.
  - Flush still suppresses the bypass: out_valid=0 during flush.
- When undefined: one-cycle minimum latency as above, with no combinational path from in_* to out_*.

Test Plan:
- Reset, then one push of in_inst=32'h0050_0093, in_pc=32'h0000_0000 with out_ready=0 → the next cycle gives out_valid=1, out_inst=32'h0050_0093, out_pc_plus4=32'h4, count=1.
- Push 4 entries (PC 0,4,8,C) with out_ready=0 → count=4, in_ready=0. A 5th in_valid is not accepted. Then pop 4 → PCs come out in order 0,4,8,C; count=0; out_inst=32'h13.
- Steady stream with push and pop every cycle for 20 cycles, with pointers wrapping → count stays at 1 and out_pc increments by 4 every cycle without a gap.
- With count=3, assert flush together with in_valid=1 → the next cycle gives count=0, out_valid=0, in_ready=1. The flushed push never appears.
- Assert rst=1 for one cycle while count=2 and in_valid=1 → the next cycle gives count=0, out_valid=0, out_pc=0, out_pc_plus4=4.
- PC wrap: push in_pc=32'hFFFF_FFFC → out_pc_plus4=32'h0000_0000. With FDQ_BYPASS_EN defined, push while empty with out_ready=1 → out_valid=1 in the same cycle and count stays 0.
